// File: rtl/ps_pad_responder.sv
// PlayStation pad device-side responder: oversamples the host's SEL/CLK/TXD,
// returns ID and button/axis bytes LSB first and generates the per-byte ACK.
module ps_pad_responder #(
  parameter int ACK_DELAY = 40,
  parameter int ACK_WIDTH = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        I_psSEL,
  input  logic        I_psCLK,
  input  logic        I_psTXD,
  output logic        O_psRXD,
  output logic        O_psACK,
  input  logic        I_analog,
  input  logic [7:0]  I_btn1,
  input  logic [7:0]  I_btn2,
  input  logic [31:0] I_axes,
  output logic [7:0]  O_cmd_data,
  output logic [3:0]  O_cmd_idx,
  output logic        O_cmd_valid,
  output logic        O_poll_done
);

  localparam int DLY_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int DLY_W   = (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_ACK_WAIT, S_ACK, S_IGNORE
  } state_t;

  function automatic logic [7:0] reply_byte(input logic [3:0] idx, input logic analog,
                                            input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [31:0] ax);
    case (idx)
      4'd0:    reply_byte = 8'hFF;
      4'd1:    reply_byte = analog ? 8'h73 : 8'h41;
      4'd2:    reply_byte = 8'h5A;
      4'd3:    reply_byte = b1;
      4'd4:    reply_byte = b2;
      4'd5:    reply_byte = ax[7:0];
      4'd6:    reply_byte = ax[15:8];
      4'd7:    reply_byte = ax[23:16];
      4'd8:    reply_byte = ax[31:24];
      default: reply_byte = 8'hFF;
    endcase
  endfunction

  // [0],[1] synchronize; [2] is the previous synchronized value for edge detect
  logic [2:0] sel_q, sclk_q;
  logic [1:0] txd_q;

  state_t            state_q, state_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              rxd_q, rxd_d, ack_q, ack_d;
  logic [7:0]        cmd_data_q, cmd_data_d;
  logic [3:0]        cmd_idx_q, cmd_idx_d;
  logic              cmd_valid_q, cmd_valid_d, poll_done_q, poll_done_d;

  logic              snap_analog_q, snap_analog_d;
  logic [7:0]        snap_btn1_q, snap_btn1_d, snap_btn2_q, snap_btn2_d;
  logic [31:0]       snap_axes_q, snap_axes_d;
  logic [7:0]        rx_q, rx_d, tx_q, tx_d;

  logic       sel_fall, sel_rise, sclk_rise, sclk_fall;
  logic [7:0] rx_byte, load_byte;
  logic [3:0] last_idx;

  assign sel_fall  =  sel_q[2]  & ~sel_q[1];
  assign sel_rise  = ~sel_q[2]  &  sel_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign rx_byte   = {txd_q[1], rx_q[7:1]};
  assign last_idx  = snap_analog_q ? 4'd8 : 4'd4;
  assign load_byte = reply_byte(byte_idx_q, snap_analog_q, snap_btn1_q, snap_btn2_q, snap_axes_q);

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    bit_cnt_d     = bit_cnt_q;
    dly_d         = dly_q;
    rxd_d         = rxd_q;
    ack_d         = ack_q;
    cmd_data_d    = cmd_data_q;
    cmd_idx_d     = cmd_idx_q;
    cmd_valid_d   = 1'b0;
    poll_done_d   = 1'b0;
    snap_analog_d = snap_analog_q;
    snap_btn1_d   = snap_btn1_q;
    snap_btn2_d   = snap_btn2_q;
    snap_axes_d   = snap_axes_q;
    rx_d          = rx_q;
    tx_d          = tx_q;

    if (sel_rise) begin
      state_d = S_IDLE;
      rxd_d   = 1'b1;
      ack_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          rxd_d = 1'b1;
          ack_d = 1'b1;
          if (sel_fall) begin
            byte_idx_d    = 4'd0;
            snap_analog_d = I_analog;
            snap_btn1_d   = I_btn1;
            snap_btn2_d   = I_btn2;
            snap_axes_d   = I_axes;
            state_d       = S_LOAD;
          end
        end
        S_LOAD: begin
          tx_d      = load_byte;
          rxd_d     = load_byte[0];
          bit_cnt_d = 3'd0;
          state_d   = S_SHIFT;
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              cmd_valid_d = 1'b1;
              cmd_data_d  = rx_byte;
              cmd_idx_d   = byte_idx_q;
              rxd_d       = 1'b1;
              dly_d       = '0;
              if ((byte_idx_q == 4'd0 && rx_byte != 8'h01) ||
                  (byte_idx_q == 4'd1 && rx_byte != 8'h42)) begin
                state_d = S_IGNORE;
              end else if (byte_idx_q == last_idx) begin
                poll_done_d = 1'b1;
                state_d     = S_IGNORE;
              end else begin
                state_d = S_ACK_WAIT;
              end
            end
          end else if (sclk_fall) begin
            // bit_cnt already points at the next bit once its predecessor was sampled
            rxd_d = tx_q[bit_cnt_q];
          end
        end
        S_ACK_WAIT: begin
          if (dly_q == DLY_W'(ACK_DELAY)) begin
            ack_d   = 1'b0;
            dly_d   = '0;
            state_d = S_ACK;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        S_ACK: begin
          if (dly_q == DLY_W'(ACK_WIDTH - 1)) begin
            ack_d      = 1'b1;
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_LOAD;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        S_IGNORE: begin
          rxd_d = 1'b1;
          ack_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q       <= 3'b111;
      sclk_q      <= 3'b111;
      txd_q       <= 2'b11;
      state_q     <= S_IDLE;
      byte_idx_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      dly_q       <= '0;
      rxd_q       <= 1'b1;
      ack_q       <= 1'b1;
      cmd_data_q  <= 8'h00;
      cmd_idx_q   <= 4'd0;
      cmd_valid_q <= 1'b0;
      poll_done_q <= 1'b0;
    end else begin
      sel_q       <= {sel_q[1:0], I_psSEL};
      sclk_q      <= {sclk_q[1:0], I_psCLK};
      txd_q       <= {txd_q[0], I_psTXD};
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      dly_q       <= dly_d;
      rxd_q       <= rxd_d;
      ack_q       <= ack_d;
      cmd_data_q  <= cmd_data_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_valid_q <= cmd_valid_d;
      poll_done_q <= poll_done_d;
    end
  end

  // Snapshot and shift registers carry data only and need no reset
  always_ff @(posedge clk) begin
    snap_analog_q <= snap_analog_d;
    snap_btn1_q   <= snap_btn1_d;
    snap_btn2_q   <= snap_btn2_d;
    snap_axes_q   <= snap_axes_d;
    rx_q          <= rx_d;
    tx_q          <= tx_d;
  end

  assign O_psRXD     = rxd_q;
  assign O_psACK     = ack_q;
  assign O_cmd_data  = cmd_data_q;
  assign O_cmd_idx   = cmd_idx_q;
  assign O_cmd_valid = cmd_valid_q;
  assign O_poll_done = poll_done_q;

endmodule

// File: tb/tb_ps_pad_responder.sv
// Scoreboard bench for ps_pad_responder: a host model drives polls, a queue-based
// reference predicts every reported byte, reply, ACK and poll completion.
module tb_ps_pad_responder;

  localparam int ACK_DELAY = 10;
  localparam int ACK_WIDTH = 6;
  localparam int HALF      = 8;
  localparam int GAP       = ACK_DELAY + ACK_WIDTH + 16;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] idx;
    logic [7:0] reply;
    bit         ack;
    bit         pd;
  } exp_t;

  typedef logic [7:0] cmd_arr_t [9];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        I_psSEL = 1'b1, I_psCLK = 1'b1, I_psTXD = 1'b1;
  logic        O_psRXD, O_psACK;
  logic        I_analog = 1'b0;
  logic [7:0]  I_btn1 = 8'hFF, I_btn2 = 8'hFF;
  logic [31:0] I_axes = 32'h0;
  logic [7:0]  O_cmd_data;
  logic [3:0]  O_cmd_idx;
  logic        O_cmd_valid, O_poll_done;

  ps_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .I_psSEL(I_psSEL), .I_psCLK(I_psCLK), .I_psTXD(I_psTXD),
    .O_psRXD(O_psRXD), .O_psACK(O_psACK),
    .I_analog(I_analog), .I_btn1(I_btn1), .I_btn2(I_btn2), .I_axes(I_axes),
    .O_cmd_data(O_cmd_data), .O_cmd_idx(O_cmd_idx),
    .O_cmd_valid(O_cmd_valid), .O_poll_done(O_poll_done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  exp_t       expq[$];
  logic [7:0] host_rx_last = 8'h00;
  bit         pending_ack  = 1'b0;
  int         valid_cyc    = 0;
  int         ack_cnt      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host shifts LSB first: CLK falls with new TXD, RXD is sampled just before CLK rises
  task automatic send_bits(input logic [7:0] b, input int nb);
    logic [7:0] cap;
    cap = 8'hFF;
    for (int k = 0; k < nb; k++) begin
      I_psCLK = 1'b0;
      I_psTXD = b[k];
      wait_clk(HALF);
      cap[k] = O_psRXD;
      if (k == 7) host_rx_last = cap;
      I_psCLK = 1'b1;
      wait_clk(HALF);
    end
    I_psTXD = 1'b1;
  endtask

  task automatic run_poll(input cmd_arr_t cmds, input int n, input int chg_idx,
                          input logic [7:0] chg_val, input int abort_byte);
    logic [7:0] rq[$];
    exp_t       e;
    bit         alive;
    int         exp_acks;
    int         last;
    rq = '{8'hFF, (I_analog ? 8'h73 : 8'h41), 8'h5A, I_btn1, I_btn2};
    if (I_analog) begin
      for (int k = 0; k < 4; k++) rq.push_back(I_axes[8*k +: 8]);
    end
    last     = rq.size() - 1;
    alive    = 1'b1;
    exp_acks = 0;
    ack_cnt  = 0;
    I_psSEL  = 1'b0;
    wait_clk(8);
    for (int i = 0; i < n; i++) begin
      if (i == chg_idx) I_btn1 = chg_val;
      if (i == abort_byte) begin
        send_bits(cmds[i], 3);
        break;
      end
      if (alive) begin
        e.cmd   = cmds[i];
        e.idx   = 4'(i);
        e.reply = rq[i];
        e.pd    = (i == last);
        e.ack   = !((i == 0 && cmds[i] != 8'h01) || (i == 1 && cmds[i] != 8'h42) || i == last);
        expq.push_back(e);
        exp_acks += int'(e.ack);
        send_bits(cmds[i], 8);
        alive = e.ack;
      end else begin
        send_bits(cmds[i], 8);
        chk("ignored_reply", host_rx_last, 8'hFF);
      end
      wait_clk(GAP);
    end
    I_psSEL = 1'b1;
    if (abort_byte >= 0) begin
      wait_clk(4);
      chk("abort_rxd", O_psRXD, 1'b1);
      chk("abort_ack", O_psACK, 1'b1);
    end
    wait_clk(12);
    chk("queue_drained", expq.size(), 0);
    chk("ack_count", ack_cnt, exp_acks);
    chk("ack_outstanding", pending_ack, 1'b0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on each reported byte and times ACK pulses
  initial begin
    exp_t e;
    bit   ack_prev;
    int   low_len;
    ack_prev = 1'b1;
    low_len  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_prev = 1'b1;
        low_len  = 0;
      end else begin
        if (O_cmd_valid) begin
          chk("prev_ack_seen", pending_ack, 1'b0);
          chk("cmd_expected", expq.size() != 0, 1'b1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("cmd_data", O_cmd_data, e.cmd);
            chk("cmd_idx", O_cmd_idx, e.idx);
            chk("reply_byte", host_rx_last, e.reply);
            chk("poll_done", O_poll_done, e.pd);
            pending_ack = e.ack;
            valid_cyc   = cyc;
          end
        end else if (O_poll_done) begin
          chk("poll_done_alone", O_poll_done, 1'b0);
        end
        if (!O_psACK && ack_prev) begin
          ack_cnt++;
          chk("ack_expected", pending_ack, 1'b1);
          chk("ack_delay", cyc - valid_cyc, ACK_DELAY + 1);
          pending_ack = 1'b0;
          low_len = 0;
        end
        if (!O_psACK) low_len++;
        if (O_psACK && !ack_prev) chk("ack_width", low_len, ACK_WIDTH);
        ack_prev = O_psACK;
      end
    end
  end

  initial begin
    cmd_arr_t cmds;
    bit       got_ack;
    exp_t     e;

    #1 reset = 1'b1;
    #2;
    chk("rst_rxd", O_psRXD, 1'b1);
    chk("rst_ack", O_psACK, 1'b1);
    chk("rst_valid", O_cmd_valid, 1'b0);
    chk("rst_done", O_poll_done, 1'b0);
    chk("rst_data", O_cmd_data, 8'h00);
    chk("rst_idx", O_cmd_idx, 4'h0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(5);

    // Digital poll
    I_analog = 1'b0; I_btn1 = 8'hEF; I_btn2 = 8'hBF;
    cmds = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_poll(cmds, 5, -1, 8'h00, -1);

    // Analog poll
    I_analog = 1'b1; I_axes = 32'h80407F10; I_btn1 = 8'h7E; I_btn2 = 8'hC3;
    run_poll(cmds, 9, -1, 8'h00, -1);

    // Bad header
    cmds[0] = 8'h81;
    run_poll(cmds, 5, -1, 8'h00, -1);

    // Abort after 3 bits of byte 3, then a clean poll
    cmds[0] = 8'h01;
    I_analog = 1'b0; I_btn1 = 8'h00;
    run_poll(cmds, 5, -1, 8'h00, 3);
    I_btn1 = 8'h5C;
    run_poll(cmds, 5, -1, 8'h00, -1);

    // Snapshot: btn1 changes mid-transaction
    I_btn1 = 8'hFF;
    run_poll(cmds, 5, 2, 8'h00, -1);
    run_poll(cmds, 5, -1, 8'h00, -1);

    // Reset while ACK is low
    I_psSEL = 1'b0;
    wait_clk(8);
    e.cmd = 8'h01; e.idx = 4'd0; e.reply = 8'hFF; e.ack = 1'b1; e.pd = 1'b0;
    expq.push_back(e);
    send_bits(8'h01, 8);
    got_ack = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!O_psACK) begin
        got_ack = 1'b1;
        break;
      end
    end
    chk("ack_before_reset", got_ack, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ack", O_psACK, 1'b1);
    chk("rst_mid_rxd", O_psRXD, 1'b1);
    chk("rst_mid_valid", O_cmd_valid, 1'b0);
    chk("rst_mid_done", O_poll_done, 1'b0);
    I_psSEL = 1'b1;
    pending_ack = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(6);
    chk("rst_mid_queue", expq.size(), 0);
    I_analog = 1'b1; I_axes = 32'h01020304; I_btn1 = 8'hA5; I_btn2 = 8'h5A;
    run_poll(cmds, 9, -1, 8'h00, -1);

    // Randomized polls
    for (int t = 0; t < 8; t++) begin
      I_analog = 1'($urandom_range(0, 1));
      I_btn1   = 8'($urandom);
      I_btn2   = 8'($urandom);
      I_axes   = $urandom;
      for (int k = 0; k < 9; k++) cmds[k] = 8'($urandom);
      cmds[0] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h01;
      cmds[1] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h42;
      run_poll(cmds, I_analog ? 9 : 5, -1, 8'h00, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
